// File: rtl/cap_state_sequencer.sv
// Bank-state sequencer for the capacitor-board FET driver: divides clk down to the
// 500 kHz carrier and applies bank states break-before-make on carrier rising edges.
module cap_state_sequencer #(
  parameter int HALF_PERIOD = 8,
  parameter int DEAD_CYCLES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       enable,
  input  logic       reqValid,
  input  logic [3:0] reqState,
  output logic       reqReady,
  output logic       clk500kHz,
  output logic [3:0] state,
  output logic       busy,
  output logic       stateChanged
);

  localparam int CNT_W  = $clog2(HALF_PERIOD);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_RUN,
    S_OFF_WAIT,
    S_DEAD,
    S_APPLY_WAIT,
    S_HOLD
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              carrier_q, carrier_d;
  logic [3:0]        state_q, state_d;
  logic [3:0]        target_q, target_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              changed_q, changed_d;
  logic              tick;

  // tick marks the cycle whose closing edge raises the carrier
  assign tick = (count_q == CNT_LAST) && !carrier_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fsm_q      <= S_RUN;
      count_q    <= '0;
      carrier_q  <= 1'b0;
      state_q    <= 4'b0000;
      target_q   <= 4'b0000;
      dead_cnt_q <= '0;
      hold_cnt_q <= '0;
      changed_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      count_q    <= count_d;
      carrier_q  <= carrier_d;
      state_q    <= state_d;
      target_q   <= target_d;
      dead_cnt_q <= dead_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      changed_q  <= changed_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    count_d    = count_q;
    carrier_d  = carrier_q;
    state_d    = state_q;
    target_d   = target_q;
    dead_cnt_d = dead_cnt_q;
    hold_cnt_d = hold_cnt_q;
    changed_d  = 1'b0;

    if (!enable) begin
      // Disable drops everything at once; a pending target is never partially applied.
      fsm_d     = S_RUN;
      count_d   = '0;
      carrier_d = 1'b0;
      state_d   = 4'b0000;
      target_d  = 4'b0000;
    end else begin
      if (count_q == CNT_LAST) begin
        count_d   = '0;
        carrier_d = ~carrier_q;
      end else begin
        count_d = count_q + 1'b1;
      end

      case (fsm_q)
        S_RUN: begin
          if (reqValid && (reqState != state_q)) begin
            target_d = reqState;
            if ((state_q == 4'b0000) || (reqState == 4'b0000)) fsm_d = S_APPLY_WAIT;
            else                                                fsm_d = S_OFF_WAIT;
          end
        end
        S_OFF_WAIT: begin
          if (tick) begin
            state_d    = 4'b0000;
            dead_cnt_d = DEAD_INIT;
            fsm_d      = S_DEAD;
          end
        end
        S_DEAD: begin
          if (tick) begin
            if (dead_cnt_q == DEAD_W'(1)) begin
              state_d    = target_q;
              changed_d  = 1'b1;
              hold_cnt_d = HOLD_INIT;
              fsm_d      = S_HOLD;
            end else begin
              dead_cnt_d = dead_cnt_q - 1'b1;
            end
          end
        end
        S_APPLY_WAIT: begin
          if (tick) begin
            state_d    = target_q;
            changed_d  = 1'b1;
            hold_cnt_d = HOLD_INIT;
            fsm_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (tick) begin
            if (hold_cnt_q == HOLD_W'(1)) fsm_d = S_RUN;
            else                          hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        default: fsm_d = S_RUN;
      endcase
    end
  end

  assign reqReady     = enable && (fsm_q == S_RUN);
  assign busy         = (fsm_q != S_RUN);
  assign clk500kHz    = carrier_q;
  assign state        = state_q;
  assign stateChanged = changed_q;

endmodule

// File: tb/tb_cap_state_sequencer.sv
// Randomized bench for cap_state_sequencer: a per-rise action-queue reference model
// predicts carrier, bank state, busy/ready and the change pulse every cycle.
module tb_cap_state_sequencer;

  localparam int HP   = 8;
  localparam int DEAD = 2;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enable;
  logic       reqValid;
  logic [3:0] reqState;
  logic       reqReady;
  logic       clk500kHz;
  logic [3:0] state;
  logic       busy;
  logic       stateChanged;

  cap_state_sequencer #(
    .HALF_PERIOD(HP),
    .DEAD_CYCLES(DEAD),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .enable      (enable),
    .reqValid    (reqValid),
    .reqState    (reqState),
    .reqReady    (reqReady),
    .clk500kHz   (clk500kHz),
    .state       (state),
    .busy        (busy),
    .stateChanged(stateChanged)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_n is clk edges since the carrier restarted (mod one period);
  // q lists what each upcoming carrier rise does: -2 blank (no pulse), -1 wait, >=0 load.
  int m_n;
  int m_state;
  int m_chg;
  int q[$];
  int prev_state;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_state = 0;
    m_chg = 0;
    q.delete();
  endtask

  task automatic model_step();
    int v;
    m_chg = 0;
    if (!enable) begin
      m_n = 0;
      m_state = 0;
      q.delete();
    end else begin
      m_n = (m_n + 1) % (2 * HP);
      if (q.size() != 0) begin
        if (m_n == HP) begin
          v = q.pop_front();
          if (v == -2) m_state = 0;
          else if (v >= 0) begin
            m_chg = (v != m_state);
            m_state = v;
          end
        end
      end else if (reqValid && (int'(reqState) != m_state)) begin
        if (m_state == 0 || reqState == 4'b0000) begin
          q.push_back(int'(reqState));
        end else begin
          q.push_back(-2);
          repeat (DEAD - 1) q.push_back(-1);
          q.push_back(int'(reqState));
        end
        repeat (HOLD) q.push_back(-1);
      end
    end
  endtask

  task automatic check_outputs();
    chk("state", int'(state), m_state);
    chk("carrier", int'(clk500kHz), int'(m_n >= HP));
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("stateChanged", int'(stateChanged), m_chg);
    chk("bbm", int'(prev_state != 0 && state != 0 && int'(state) != prev_state), 0);
    prev_state = int'(state);
  endtask

  task automatic drive_random();
    int r;
    enable   = ($urandom_range(0, 299) != 0);
    reqValid = ($urandom_range(0, 1) == 1);
    r = $urandom_range(0, 3);
    if (r == 0)      reqState = 4'b0000;
    else if (r == 1) reqState = 4'(m_state);
    else             reqState = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rstN = 1'b0;
    enable = 1'b1;
    reqValid = 1'b0;
    reqState = 4'b0000;
    model_reset();
    prev_state = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_carrier", int'(clk500kHz), 0);
    chk("reset_changed", int'(stateChanged), 0);
    chk("reset_busy", int'(busy), 0);
    rstN = 1'b1;

    for (int cyc = 0; cyc < 8000; cyc++) begin
      // Hold requests idle for the first carrier periods so the free-running divider is seen alone.
      if (cyc < 40) begin
        enable = 1'b1;
        reqValid = 1'b0;
      end else begin
        drive_random();
      end
      #1;
      chk("reqReady", int'(reqReady), int'(enable && q.size() == 0));
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();

      if (cyc > 40 && $urandom_range(0, 1499) == 0) begin
        rstN = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_carrier", int'(clk500kHz), 0);
        chk("async_rst_changed", int'(stateChanged), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        prev_state = 0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cap_state_sequencer.md
Name: cap_state_sequencer

Overview:
- Sits directly upstream of the capacitor-board FET driver stage.
- Generates that stage's 500 kHz carrier (clk500kHz) by dividing the system clock.
- Produces the 4-bit bank state, changed only on carrier rising edges so the driver never emits runt pulses.
- Enforces break-before-make: all banks off for a dead interval between non-trivial state changes, then a minimum hold time before the next command is accepted.

Parameters:
HALF_PERIOD, 8, clk cycles per carrier half-period (8 MHz clk -> 500 kHz); legal range >=2
DEAD_CYCLES, 2, whole carrier periods with state=0 between two non-zero states; legal range >=1
HOLD_CYCLES, 4, whole carrier periods a newly applied state is held before the next request is accepted; legal range >=1

Ports:
clk  input  1  system clock
rstN  input  1  asynchronous active-low reset
enable  input  1  run enable; low forces banks off and stops the carrier
reqValid  input  1  new bank-state request valid
reqState  input  4  requested bank state, one bit per cap bank
reqReady  output  1  request accepted this cycle when reqValid&reqReady
clk500kHz  output  1  carrier square wave to the FET driver
state  output  4  registered bank state to the FET driver
busy  output  1  sequencer is not in RUN
stateChanged  output  1  one-cycle pulse when state is loaded with a new target

Behaviour:
- Clock and reset: single clock domain on clk; rstN is asynchronous, active-low.
- Reset values: divider count 0, clk500kHz 0, state 0, FSM RUN, stateChanged 0, target register 0.
- Divider: count runs 0..HALF_PERIOD-1 and wraps; clk500kHz toggles on the edge where count==HALF_PERIOD-1.
- tick: asserted in the cycle where count==HALF_PERIOD-1 and clk500kHz==0. Every state register update happens on the same edge that clk500kHz rises.
- enable=0: on the next edge, count is 0, clk500kHz is 0, state is 0 and the FSM is in RUN. Any pending target is discarded and no stateChanged pulse is issued. While enable=0, reqReady=0 and busy=0.
- reqReady = enable & (FSM==RUN), combinational. busy = (FSM!=RUN).
- reqState is sampled only on accept. reqValid while not ready is ignored; the requester must hold the request.
- FSM RUN, on accept with reqState==state: stay in RUN, no pulse; this is a one-cycle no-op accept.
- FSM RUN, on accept with reqState!=state: latch target and go to APPLY_WAIT if state==0 or target==0; otherwise go to OFF_WAIT.
- OFF_WAIT: on tick, state<=0, deadCnt<=DEAD_CYCLES, go to DEAD.
- DEAD: on each tick, deadCnt decrements. On the tick where deadCnt==1, state<=target, stateChanged pulses, holdCnt<=HOLD_CYCLES, go to HOLD.
- APPLY_WAIT: on tick, state<=target, stateChanged pulses, holdCnt<=HOLD_CYCLES, go to HOLD.
- HOLD: on each tick, holdCnt decrements. On the tick where holdCnt==1, go to RUN, so reqReady rises the following cycle.
- Resulting dead interval is exactly DEAD_CYCLES carrier periods with state=0.
- A transition to state 0 pulses stateChanged and still serves HOLD.
- stateChanged pulses only in the cycle after the edge that loads a target value different from the previous state; it is never asserted for the entry into dead time.
- Counters are wide enough for the parameter maxima (clog2) and never wrap within an operation.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously.
- enable deasserted mid-operation: handled as in the enable=0 rule above, with no partial target applied.

Test Plan:
All scenarios use HALF_PERIOD=8, DEAD_CYCLES=2, HOLD_CYCLES=4.
1. Release rstN with enable=1 -> clk500kHz first rises 8 clk after release, then toggles every 8 clk (16-clk period); state=0, reqReady=1, busy=0.
2. From state 0, request 4'b0101 -> accepted in one cycle; state=0101 at the next clk500kHz rise with a one-cycle stateChanged pulse; busy for 4 carrier periods (64 clk from apply), then reqReady=1.
3. From 0101, request 0011 -> state=0 at the next rise; state holds 0 for exactly 32 clk; state=0011 on the following rise with a stateChanged pulse; no cycle ever shows a 0101/0011 overlap.
4. From 0011, request 0011 -> reqReady stays 1, busy never asserts, no stateChanged pulse, state unchanged.
5. Drop enable during DEAD -> on the next edge state=0, clk500kHz=0, busy=0, reqReady=0. Re-raise enable and request 1000 -> applies via APPLY_WAIT at the first rise, with no dead interval.
6. Hold reqValid with 1111 throughout HOLD after an apply -> not accepted until reqReady returns. Then assert rstN=0 mid-HOLD -> state, clk500kHz and stateChanged go to 0 immediately, and no request is pending after release.
